// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding and baud divisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clocks per oversample tick, integer floor.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_rate_generator.sv
// ============================================================================
// Module      : baud_rate_generator
// Description : Free-running divider producing a one-cycle oversample tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_rate_generator
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int c_div   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 16x oversampled UART receiver with framing error detection.
//               Optional even parity check enabled by UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int NB_DATA    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_uart_rx_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_error,
`endif
    output logic               o_busy
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(NB_DATA - 1);

    uart_state_t        r_state;
    logic               r_sync1;
    logic               r_rx_s;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [NB_DATA-1:0] r_shift;
    logic               w_tick;
`ifdef UART_RX_PARITY_EN
    logic               r_parity_bit;
`endif

    baud_rate_generator #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx_data;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            o_data         <= '0;
            o_rx_done      <= 1'b0;
            o_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit   <= 1'b0;
            o_parity_error <= 1'b0;
`endif
        end else begin
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_error <= 1'b0;
`endif
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!r_rx_s) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == c_tick_mid) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= r_rx_s ? IDLE : DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_s, r_shift[NB_DATA-1:1]};
                            if (r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt   <= '0;
                            r_parity_bit <= r_rx_s;
                            r_state      <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt <= '0;
                            r_state    <= IDLE;
                            if (!r_rx_s) begin
                                o_frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (^{r_shift, r_parity_bit}) begin
                                o_parity_error <= 1'b1;
`endif
                            end else begin
                                o_data    <= r_shift;
                                o_rx_done <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (DIV=4, 64 clk/bit).
//               Parity scenario included when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_error;
    logic       o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_error;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (16),
        .NB_DATA    (8)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_uart_rx_data (rx),
        .o_data         (o_data),
        .o_rx_done      (o_rx_done),
        .o_frame_error  (o_frame_error),
`ifdef UART_RX_PARITY_EN
        .o_parity_error (o_parity_error),
`endif
        .o_busy         (o_busy)
    );

    // Strobe monitor: counts events, records received bytes, flags width/exclusivity faults.
    int         n_done = 0;
    int         n_fe   = 0;
    int         n_pe   = 0;
    int         n_viol = 0;
    logic [7:0] got[$];
    logic       prev_done = 1'b0;
    logic       prev_fe   = 1'b0;

    always @(negedge clk) begin
        if (o_rx_done) begin
            n_done++;
            got.push_back(o_data);
        end
        if (o_frame_error) n_fe++;
        if ((o_rx_done && o_frame_error) || (o_rx_done && prev_done) || (o_frame_error && prev_fe))
            n_viol++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_error) begin
            n_pe++;
            if (o_rx_done || o_frame_error) n_viol++;
        end
`endif
        prev_done = o_rx_done;
        prev_fe   = o_frame_error;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^data : ~(^data));
`else
        if (!par_ok) rx = 1'b1;
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(5);
        #1;
        checks++; if (o_data !== 8'h00)     begin errors++; $display("FAIL reset_data got=%h exp=00", o_data); end
        checks++; if (o_rx_done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", o_rx_done); end
        checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", o_frame_error); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        rst = 1'b0;
        wait_clks(2000);
        #1;
        checks++; if (n_done !== 0 || n_fe !== 0) begin errors++; $display("FAIL idle_strobes got done=%0d fe=%0d exp 0/0", n_done, n_fe); end
        checks++; if (o_busy !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL idle_state got busy=%b data=%h exp 0/00", o_busy, o_data); end
    endtask

    task automatic test_good_frame();
        int d0 = n_done;
        int f0 = n_fe;
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_clks(20);
        #1;
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL good_count got=%0d exp=1", n_done - d0); end
        checks++; if (o_data !== 8'hA5)  begin errors++; $display("FAIL good_data got=%h exp=a5", o_data); end
        checks++; if (n_fe - f0 !== 0)   begin errors++; $display("FAIL good_fe got=%0d exp=0", n_fe - f0); end
    endtask

    task automatic test_frame_error();
        int d0 = n_done;
        int f0 = n_fe;
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clks(100);
        #1;
        checks++; if (n_fe - f0 !== 1)   begin errors++; $display("FAIL ferr_count got=%0d exp=1", n_fe - f0); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL ferr_done got=%0d exp=0", n_done - d0); end
        checks++; if (o_data !== 8'hA5)  begin errors++; $display("FAIL ferr_data got=%h exp=a5", o_data); end
        checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL ferr_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_glitch();
        int d0 = n_done;
        int f0 = n_fe;
        rx = 1'b0;
        wait_clks(10);
        #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got=%b exp=1", o_busy); end
        wait_clks(10);
        rx = 1'b1;
        wait_clks(44);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got=%b exp=0", o_busy); end
        wait_clks(700);
        #1;
        checks++; if (n_done - d0 !== 0 || n_fe - f0 !== 0) begin errors++; $display("FAIL glitch_strobes got done=%0d fe=%0d exp 0/0", n_done - d0, n_fe - f0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v[3] = '{8'h00, 8'hFF, 8'h55};
        int base = got.size();
        int f0 = n_fe;
        for (int i = 0; i < 3; i++) send_frame(exp_v[i], 1'b1, 1'b1);
        wait_clks(100);
        #1;
        checks++; if (got.size() - base !== 3 || n_fe - f0 !== 0) begin errors++; $display("FAIL b2b_count got=%0d fe=%0d exp 3/0", got.size() - base, n_fe - f0); end
        for (int i = 0; i < 3; i++) begin
            if (base + i < got.size()) begin
                checks++; if (got[base+i] !== exp_v[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got[base+i], exp_v[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v = 8'h81;
        int d0 = n_done;
        int f0 = n_fe;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        rx = v[4];
        wait_clks(32);
        rst = 1'b1;
        wait_clks(4);
        #1;
        checks++; if (o_busy !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL midrst_state got busy=%b data=%h exp 0/00", o_busy, o_data); end
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clks(200);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_clks(20);
        #1;
        checks++; if (n_done - d0 !== 1 || n_fe - f0 !== 0) begin errors++; $display("FAIL midrst_count got done=%0d fe=%0d exp 1/0", n_done - d0, n_fe - f0); end
        checks++; if (o_data !== 8'h7E) begin errors++; $display("FAIL midrst_data got=%h exp=7e", o_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int d0 = n_done;
        int p0 = n_pe;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(20);
        #1;
        checks++; if (n_pe - p0 !== 1)   begin errors++; $display("FAIL parity_count got=%0d exp=1", n_pe - p0); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL parity_done got=%0d exp=0", n_done - d0); end
        checks++; if (o_data !== 8'h7E)  begin errors++; $display("FAIL parity_data got=%h exp=7e", o_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++; if (n_viol !== 0) begin errors++; $display("FAIL strobe_rules got=%0d exp=0", n_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
